ready_proxy: RTL and testbench

- Valid/ready register slice ("skid buffer") that registers the backward `ready` path as well as the forward `valid`/`data` path.
- No combinational path exists from any down_* input to any up_* output, or from any up_* input to any down_* output.
- Inserted between a source and a sink to cut long `ready` timing paths. Sustains full throughput (1 transfer/cycle) with 1-cycle latency.
- Internal storage: one main register plus one skid register.

---
 rtl/ready_proxy_pkg.sv | 13 +
 rtl/ready_proxy_if.sv | 31 +++
 rtl/ready_proxy.sv | 97 +++++++++
 tb/tb_ready_proxy.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ready_proxy_pkg.sv
// Shared types for the ready_proxy register slice: state encoding and its width.
package ready_proxy_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY   = 2'd0,
        ST_BUSY    = 2'd1,
        ST_FULL    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

endpackage

// File: rtl/ready_proxy_if.sv
// Valid/ready handshake bundle seen by ready_proxy: upstream source side plus downstream sink side.
interface ready_proxy_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] up_data;
    logic                  up_valid;
    logic                  up_ready;
    logic [DATA_WIDTH-1:0] down_data;
    logic                  down_valid;
    logic                  down_ready;

    // Slice view
    modport slave (
        input  up_data,
        input  up_valid,
        input  down_ready,
        output up_ready,
        output down_data,
        output down_valid
    );

    // Environment view: drives the source and the sink's ready
    modport master (
        output up_data,
        output up_valid,
        output down_ready,
        input  up_ready,
        input  down_data,
        input  down_valid
    );
endinterface

// File: rtl/ready_proxy.sv
// Skid-buffer register slice: registers valid/data forward and ready backward,
// full throughput, one-cycle latency, main register plus one skid register.
module ready_proxy
    import ready_proxy_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    ready_proxy_if.slave   bus
);

    state_e                state;
    state_e                next_state;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  down_valid_q;
    logic                  up_ready_q;
    logic                  up_fire;
    logic                  down_fire;
    logic                  load_main_up;
    logic                  load_main_skid;
    logic                  load_skid;

    assign up_fire   = bus.up_valid & up_ready_q;
    assign down_fire = down_valid_q & bus.down_ready;

    assign bus.up_ready   = up_ready_q;
    assign bus.down_valid = down_valid_q;
    assign bus.down_data  = main_q;

    // State, handshake flags and storage
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_EMPTY;
            down_valid_q <= 1'b0;
            up_ready_q   <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            state        <= next_state;
            down_valid_q <= (next_state != ST_EMPTY);
            up_ready_q   <= (next_state != ST_FULL);
            if (load_main_up) begin
                main_q <= bus.up_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= bus.up_data;
            end
        end
    end

    // Next state and register load enables
    always_comb begin
        next_state     = state;
        load_main_up   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (up_fire) begin
                    next_state   = ST_BUSY;
                    load_main_up = 1'b1;
                end
            end
            ST_BUSY: begin
                if (up_fire && down_fire) begin
                    load_main_up = 1'b1;
                end else if (up_fire) begin
                    next_state = ST_FULL;
                    load_skid  = 1'b1;
                end else if (down_fire) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (down_fire) begin
                    next_state     = ST_BUSY;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                next_state = ST_EMPTY;
            end
        endcase
    end

    a_state_legal : assert property (@(posedge clk) disable iff (rst)
        state != ST_ILLEGAL);

    // A stalled beat must not change under the sink
    a_stall_stable : assert property (@(posedge clk) disable iff (rst)
        (down_valid_q && !bus.down_ready) |=> (down_valid_q && $stable(main_q)));

endmodule

// File: tb/tb_ready_proxy.sv
// Scoreboarded directed and random test of the ready_proxy skid buffer.
module tb_ready_proxy;
    import ready_proxy_pkg::*;

    localparam int unsigned DW = 8;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [DW-1:0] sb[$];
    logic          prev_stall;
    logic [DW-1:0] prev_data;

    ready_proxy_if #(.DATA_WIDTH(DW)) bus ();

    ready_proxy #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat; expected value is queued on the cycle it is seen accepted
    task automatic send(input logic [DW-1:0] d);
        bit done;
        done = 0;
        bus.up_valid = 1'b1;
        bus.up_data  = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.up_ready) begin
                sb.push_back(d);
                done = 1;
            end
            step();
        end
        check("send_accepted", 32'(done), 32'd1);
        bus.up_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Output monitor: every down fire pops and compares; stalls must hold the beat
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("stall_valid", 32'(bus.down_valid), 32'd1);
                check("stall_data", 32'(bus.down_data), 32'(prev_data));
            end
            if (bus.down_valid && bus.down_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    check("sb_data", 32'(bus.down_data), 32'(sb.pop_front()));
                end
            end
        end
        prev_stall = !rst && bus.down_valid && !bus.down_ready;
        prev_data  = bus.down_data;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests          = 0;
        fails          = 0;
        prev_stall     = 1'b0;
        prev_data      = '0;
        rst            = 1'b1;
        bus.up_valid   = 1'b0;
        bus.up_data    = '0;
        bus.down_ready = 1'b0;

        // Reset release
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rel0_up_ready", 32'(bus.up_ready), 32'd0);
        check("rel0_down_valid", 32'(bus.down_valid), 32'd0);
        check("rel0_down_data", 32'(bus.down_data), 32'h00);
        step();
        @(negedge clk);
        check("rel1_up_ready", 32'(bus.up_ready), 32'd1);
        check("rel1_down_valid", 32'(bus.down_valid), 32'd0);
        step();

        // Streaming 0x01..0x10 with no bubbles
        bus.down_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus.up_valid = 1'b1;
            bus.up_data  = DW'(i);
            @(negedge clk);
            check("stream_up_ready", 32'(bus.up_ready), 32'd1);
            if (bus.up_ready) sb.push_back(DW'(i));
            if (i > 1) begin
                check("stream_valid", 32'(bus.down_valid), 32'd1);
                check("stream_data", 32'(bus.down_data), 32'(i - 1));
            end
            step();
        end
        bus.up_valid = 1'b0;
        @(negedge clk);
        check("stream_last", 32'(bus.down_data), 32'h10);
        step();
        idle(3);
        check("stream_drained", 32'(sb.size()), 32'd0);

        // Skid fill and drain
        bus.down_ready = 1'b0;
        send(8'hA1);
        @(negedge clk);
        check("skid_state_busy", 32'(dut.state), 32'(ST_BUSY));
        check("skid_busy_ready", 32'(bus.up_ready), 32'd1);
        check("skid_busy_data", 32'(bus.down_data), 32'hA1);
        step();
        send(8'hA2);
        @(negedge clk);
        check("skid_state_full", 32'(dut.state), 32'(ST_FULL));
        check("skid_full_ready", 32'(bus.up_ready), 32'd0);
        check("skid_full_data", 32'(bus.down_data), 32'hA1);
        step();
        idle(2);
        @(negedge clk);
        check("skid_hold_data", 32'(bus.down_data), 32'hA1);
        step();
        bus.down_ready = 1'b1;
        step();
        @(negedge clk);
        check("drain1_data", 32'(bus.down_data), 32'hA2);
        check("drain1_ready", 32'(bus.up_ready), 32'd1);
        step();
        send(8'hA3);
        idle(3);
        check("skid_drained", 32'(sb.size()), 32'd0);

        // Simultaneous in/out in BUSY
        bus.down_ready = 1'b0;
        send(8'h55);
        bus.down_ready = 1'b1;
        send(8'h66);
        @(negedge clk);
        check("simul_state", 32'(dut.state), 32'(ST_BUSY));
        check("simul_data", 32'(bus.down_data), 32'h66);
        step();
        @(negedge clk);
        check("simul_empty", 32'(bus.down_valid), 32'd0);
        step();

        // Reset while FULL flushes both entries
        bus.down_ready = 1'b0;
        send(8'h11);
        send(8'h22);
        @(negedge clk);
        check("rst_pre_full", 32'(dut.state), 32'(ST_FULL));
        step();
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_down_valid", 32'(bus.down_valid), 32'd0);
        check("rst_up_ready", 32'(bus.up_ready), 32'd0);
        step();
        bus.down_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_valid", 32'(bus.down_valid), 32'd0);
            check("rst_no_stale", 32'(bus.down_data == 8'h11 || bus.down_data == 8'h22), 32'd0);
            step();
        end

        // Random stress
        for (int c = 0; c < 10000; c++) begin
            bus.up_valid   = 1'($urandom_range(1));
            bus.up_data    = DW'($urandom);
            bus.down_ready = 1'($urandom_range(1));
            @(negedge clk);
            if (bus.up_valid && bus.up_ready) sb.push_back(bus.up_data);
            step();
        end
        bus.up_valid   = 1'b0;
        bus.down_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        check("stress_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
